// File: rtl/one_hot_demux.sv
// Request dispatcher: routes one accepted request as a held one-hot valid to
// the selected slice, waits for that slice's acknowledge (or a timeout) and
// answers with a one-cycle response pulse carrying an error flag.
module one_hot_demux #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned CNT           = 5,
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned ONE_HOT_CHECK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [CNT-1:0]   req_sel,
  input  logic             req_wr,
  input  logic [WIDTH-1:0] req_data,
  output logic [CNT-1:0]   dst_vld,
  output logic             dst_wr,
  output logic [WIDTH-1:0] dst_data,
  input  logic [CNT-1:0]   dst_ack,
  output logic             ack_vld,
  output logic             err
);

  // Counter only has to reach TIMEOUT-1; keep at least one bit.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e          state_q;
  logic [CNT-1:0]  sel_q;
  logic [CntW-1:0] cnt_q;

  logic sel_ok;
  logic sel_bad;
  logic hit;
  logic tmo;

  // Decode select legality, acknowledge hit and timeout condition.
  always_comb begin
    sel_ok  = (req_sel != '0) && ((req_sel & (req_sel - 1'b1)) == '0);
    sel_bad = (ONE_HOT_CHECK != 0) && !sel_ok;
    hit     = |(dst_ack & sel_q);
    tmo     = (TIMEOUT != 0) && (cnt_q == CntLast);
  end

  // Single FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      cnt_q    <= '0;
      req_rdy  <= 1'b0;
      dst_vld  <= '0;
      dst_wr   <= 1'b0;
      dst_data <= '0;
      ack_vld  <= 1'b0;
      err      <= 1'b0;
    end else begin
      // Response qualifiers are pulses unless a branch below raises them.
      ack_vld <= 1'b0;
      err     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          req_rdy <= 1'b1;
          if (req_vld && req_rdy) begin
            sel_q    <= req_sel;
            dst_wr   <= req_wr;
            dst_data <= req_data;
            cnt_q    <= '0;
            req_rdy  <= 1'b0;
            if (sel_bad) begin
              // Bad select: answer at once, never touch the slices.
              state_q <= StResp;
              ack_vld <= 1'b1;
              err     <= 1'b1;
            end else begin
              state_q <= StWait;
              dst_vld <= req_sel;
            end
          end
        end
        StWait: begin
          if (hit) begin
            // Acknowledge wins over a coincident timeout.
            state_q <= StResp;
            dst_vld <= '0;
            ack_vld <= 1'b1;
          end else if (tmo) begin
            state_q <= StResp;
            dst_vld <= '0;
            ack_vld <= 1'b1;
            err     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          state_q  <= StIdle;
          req_rdy  <= 1'b1;
          sel_q    <= '0;
          dst_wr   <= 1'b0;
          dst_data <= '0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_one_hot_demux.sv
// Scoreboard bench for one_hot_demux: the driver pushes the expected outcome
// of each request, a negedge monitor pops and compares on every response.
module tb_one_hot_demux;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned CNT     = 5;
  localparam int unsigned TIMEOUT = 12;

  logic             clk;
  logic             rst_n;
  logic             req_vld;
  logic             req_rdy;
  logic [CNT-1:0]   req_sel;
  logic             req_wr;
  logic [WIDTH-1:0] req_data;
  logic [CNT-1:0]   dst_vld;
  logic             dst_wr;
  logic [WIDTH-1:0] dst_data;
  logic [CNT-1:0]   dst_ack;
  logic             ack_vld;
  logic             err;

  one_hot_demux #(
    .WIDTH        (WIDTH),
    .CNT          (CNT),
    .TIMEOUT      (TIMEOUT),
    .ONE_HOT_CHECK(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .req_sel (req_sel),
    .req_wr  (req_wr),
    .req_data(req_data),
    .dst_vld (dst_vld),
    .dst_wr  (dst_wr),
    .dst_data(dst_data),
    .dst_ack (dst_ack),
    .ack_vld (ack_vld),
    .err     (err)
  );

  typedef struct {
    logic [CNT-1:0]   sel;
    logic             wr;
    logic [WIDTH-1:0] data;
    logic             err;
    int               edges;  // edges after accept until ack_vld is seen high
    int               waitc;  // cycles dst_vld is high
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   vld_cnt = 0;
  bit   prev_ack = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: outcome follows from select legality, ack time and timeout.
  function automatic exp_t model(input logic [CNT-1:0] sel, input logic wr,
                                 input logic [WIDTH-1:0] data, input int ack_k);
    exp_t e;
    e.sel  = sel;
    e.wr   = wr;
    e.data = data;
    if ($countones(sel) != 1) begin
      e.err = 1'b1; e.edges = 0; e.waitc = 0;
    end else if (ack_k != 0 && ack_k <= int'(TIMEOUT)) begin
      e.err = 1'b0; e.edges = ack_k; e.waitc = ack_k;
    end else begin
      e.err = 1'b1; e.edges = TIMEOUT; e.waitc = TIMEOUT;
    end
    return e;
  endfunction

  // Present a request and return just after the accepting edge.
  task automatic issue(input logic [CNT-1:0] sel, input logic wr,
                       input logic [WIDTH-1:0] data, input int ack_k);
    int n;
    q.push_back(model(sel, wr, data, ack_k));
    req_sel  = sel;
    req_wr   = wr;
    req_data = data;
    req_vld  = 1'b1;
    n = 0;
    while (!req_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_rdy) chk("accept_bound", 1'b0, 1'b1);
    @(posedge clk); #1;
    // Scramble inputs so a non-capturing design shows up on dst_data/dst_wr.
    req_vld  = 1'b0;
    req_sel  = CNT'($urandom);
    req_wr   = 1'($urandom);
    req_data = $urandom;
  endtask

  task automatic run_req(input logic [CNT-1:0] sel, input logic wr,
                         input logic [WIDTH-1:0] data, input int ack_k, input bit level,
                         input bit rand_noise, input logic [CNT-1:0] fixed_noise);
    int k;
    logic [CNT-1:0] noise;
    issue(sel, wr, data, ack_k);
    k = 1;
    while (!ack_vld && k <= 60) begin
      noise   = rand_noise ? (CNT'($urandom) & ~sel) : (fixed_noise & ~sel);
      dst_ack = noise | (((k == ack_k) || (level && ack_k != 0 && k > ack_k)) ? sel : '0);
      @(posedge clk); #1;
      k++;
    end
    if (!ack_vld) chk("resp_bound", 1'b0, 1'b1);
    dst_ack = CNT'($urandom);  // acks during RESP must be ignored
    @(posedge clk); #1;
    dst_ack = '0;
  endtask

  // Accept timestamping on the active edge (inputs are stable here).
  always @(posedge clk) begin
    if (rst_n && req_vld && req_rdy) accept_cyc = cyc;
    cyc++;
  end

  // Monitor: per-cycle protocol checks and scoreboard pop on every response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      vld_cnt  = 0;
      prev_ack = 1'b0;
    end else begin
      if (!ack_vld) chk("err_without_ack", err, 1'b0);
      if (prev_ack) begin
        chk("ack_one_cycle", ack_vld, 1'b0);
        chk("rdy_after_resp", req_rdy, 1'b1);
      end
      if (req_rdy) begin
        chk("idle_dst_vld", dst_vld, '0);
        chk("idle_dst_data", dst_data, '0);
        chk("idle_dst_wr", dst_wr, 1'b0);
      end
      if (dst_vld != '0) begin
        vld_cnt++;
        if (q.size() > 0) begin
          chk("dst_vld", dst_vld, q[0].sel);
          chk("dst_data", dst_data, q[0].data);
          chk("dst_wr", dst_wr, q[0].wr);
        end else begin
          chk("dst_vld_unexpected", dst_vld, '0);
        end
      end
      if (ack_vld) begin
        chk("resp_dst_vld", dst_vld, '0);
        chk("resp_req_rdy", req_rdy, 1'b0);
        if (q.size() == 0) begin
          chk("ack_unexpected", ack_vld, 1'b0);
        end else begin
          e = q.pop_front();
          chk("resp_err", err, e.err);
          chk("resp_latency", 64'(cyc - accept_cyc - 1), 64'(e.edges));
          chk("dst_vld_cycles", 64'(vld_cnt), 64'(e.waitc));
        end
        vld_cnt = 0;
      end
      prev_ack = ack_vld;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CNT-1:0] s;
    clk      = 1'b0;
    rst_n    = 1'b0;
    req_vld  = 1'b0;
    req_sel  = '0;
    req_wr   = 1'b0;
    req_data = '0;
    dst_ack  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_rdy", req_rdy, 1'b0);
    chk("rst_dst_vld", dst_vld, '0);
    chk("rst_ack_vld", ack_vld, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_dst_data", dst_data, '0);
    rst_n = 1'b1;
    chk("rel_req_rdy_low", req_rdy, 1'b0);
    @(posedge clk); #1;
    chk("rel_req_rdy_high", req_rdy, 1'b1);

    // Directed cases.
    run_req(5'b00100, 1'b1, 32'hA5A5_0001, 1, 1'b0, 1'b0, '0);
    run_req(5'b00001, 1'b0, 32'h1234_5678, 10, 1'b0, 1'b0, 5'b00010);
    run_req(5'b01000, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, '0);
    run_req(5'b10000, 1'b1, 32'h0000_0042, 2, 1'b1, 1'b1, '0);
    run_req(5'b00110, 1'b1, 32'h0BAD_0001, 1, 1'b0, 1'b1, '0);
    run_req(5'b00000, 1'b0, 32'h0BAD_0002, 1, 1'b0, 1'b1, '0);
    run_req(5'b00010, 1'b0, 32'hC01C_0003, TIMEOUT, 1'b0, 1'b1, '0);
    run_req(5'b00010, 1'b0, 32'hC01C_0004, TIMEOUT + 1, 1'b0, 1'b1, '0);

    // Reset in the middle of WAIT: transaction dropped, no response.
    issue(5'b00010, 1'b1, 32'h5555_AAAA, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_req_rdy", req_rdy, 1'b0);
    chk("midrst_dst_vld", dst_vld, '0);
    chk("midrst_dst_wr", dst_wr, 1'b0);
    chk("midrst_dst_data", dst_data, '0);
    chk("midrst_ack_vld", ack_vld, 1'b0);
    chk("midrst_err", err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrel_req_rdy_low", req_rdy, 1'b0);
    @(posedge clk); #1;
    chk("midrel_req_rdy_high", req_rdy, 1'b1);
    chk("midrel_no_ack", ack_vld, 1'b0);
    run_req(5'b00001, 1'b1, 32'hFEED_0001, 3, 1'b0, 1'b1, '0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 7) s = CNT'(1) << $urandom_range(0, CNT - 1);
      else s = CNT'($urandom);
      run_req(s, 1'($urandom), $urandom, int'($urandom_range(0, TIMEOUT + 3)),
              1'($urandom), 1'b1, '0);
      repeat ($urandom_range(0, 2)) begin
        dst_ack = CNT'($urandom);
        @(posedge clk); #1;
      end
      dst_ack = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
